ptmch_trg_seq: RTL

Trigger-pulse sequencer for the ptmch trigger path. It holds a pulse-train configuration (start delay, pulse width, period, repeat count) written by the SPI command decoder. On a start command it drives a cycle-exact train of trigger pulses on `TRG_PLS` in the `CLK200M` domain. It also reports busy/done status and rejects illegal configurations or writes made while a train is running.

---
 rtl/ptmch_trg_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ptmch_trg_seq.sv
// ptmch_trg_seq: trigger-pulse sequencer for the ptmch trigger path.
// Holds a pulse-train configuration (delay, width, period, repeat count)
// written by the SPI command decoder and, on a start command, drives a
// cycle-exact train of pulses on TRG_PLS. Reports busy/done status and flags
// rejected writes or starts on CFG_ERR.

module ptmch_trg_seq #(
   parameter int CNT_W = 16,
   parameter int REP_W = 8
) (
   input  logic             CLK200M,
   input  logic             RESET,
   input  logic             CFG_WE,
   input  logic [1:0]       CFG_ADDR,
   input  logic [CNT_W-1:0] CFG_WDATA,
   input  logic             START,
   input  logic             ABORT,
   output logic             TRG_PLS,
   output logic             BUSY,
   output logic             DONE,
   output logic             CFG_ERR
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_t;

   // Configuration registers, visible to the SPI decoder side.
   logic [CNT_W-1:0] dly_cfg_r;
   logic [CNT_W-1:0] wid_cfg_r;
   logic [CNT_W-1:0] per_cfg_r;
   logic [REP_W-1:0] rep_cfg_r;

   // Working copies captured at start; the running train only uses these.
   // The low-phase length is stored pre-computed as PERIOD-WIDTH.
   logic [CNT_W-1:0] wid_wrk_r, wid_wrk_nx_s;
   logic [CNT_W-1:0] gap_wrk_r, gap_wrk_nx_s;

   // Sequencer state: cnt_r holds the remaining cycles of the current phase
   // minus one; rep_r holds the number of pulses still to emit, including the
   // one currently in progress.
   state_t           state_r, state_nx_s;
   logic [CNT_W-1:0] cnt_r, cnt_nx_s;
   logic [REP_W-1:0] rep_r, rep_nx_s;

   logic             trg_pls_r;
   logic             busy_r;
   logic             done_r;
   logic             cfg_err_r;
   logic             done_nx_s;
   logic             err_nx_s;
   logic             cfg_ok_s;
   logic             idle_s;

   assign idle_s   = (state_r == ST_IDLE);

   // Legal train: non-zero width, a low gap of at least one cycle, at least one pulse.
   assign cfg_ok_s = (wid_cfg_r != {CNT_W{1'b0}}) &&
                     (per_cfg_r > wid_cfg_r) &&
                     (rep_cfg_r != {REP_W{1'b0}});

   // Next-state, counter reload and status-pulse decode.
   always_comb begin
      state_nx_s   = state_r;
      cnt_nx_s     = cnt_r;
      rep_nx_s     = rep_r;
      wid_wrk_nx_s = wid_wrk_r;
      gap_wrk_nx_s = gap_wrk_r;
      done_nx_s    = 1'b0;
      err_nx_s     = 1'b0;

      case (state_r)
         ST_IDLE: begin
            // ABORT in IDLE cancels a simultaneous start and suppresses its error.
            if (START && !ABORT) begin
               if (cfg_ok_s) begin
                  wid_wrk_nx_s = wid_cfg_r;
                  gap_wrk_nx_s = per_cfg_r - wid_cfg_r;
                  rep_nx_s     = rep_cfg_r;
                  if (dly_cfg_r != {CNT_W{1'b0}}) begin
                     state_nx_s = ST_DELAY;
                     cnt_nx_s   = dly_cfg_r - CNT_W'(1'b1);
                  end else begin
                     state_nx_s = ST_HIGH;
                     cnt_nx_s   = wid_cfg_r - CNT_W'(1'b1);
                  end
               end else begin
                  err_nx_s = 1'b1;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end

         ST_DELAY: begin
            if (ABORT) begin
               state_nx_s = ST_IDLE;
            end else if (cnt_r == {CNT_W{1'b0}}) begin
               state_nx_s = ST_HIGH;
               cnt_nx_s   = wid_wrk_r - CNT_W'(1'b1);
            end else begin
               cnt_nx_s = cnt_r - CNT_W'(1'b1);
            end
         end

         ST_HIGH: begin
            if (ABORT) begin
               state_nx_s = ST_IDLE;
            end else if (cnt_r == {CNT_W{1'b0}}) begin
               if (rep_r == REP_W'(1'b1)) begin
                  // Last pulse: no trailing gap, straight back to IDLE.
                  state_nx_s = ST_IDLE;
                  done_nx_s  = 1'b1;
               end else begin
                  state_nx_s = ST_LOW;
                  cnt_nx_s   = gap_wrk_r - CNT_W'(1'b1);
                  rep_nx_s   = rep_r - REP_W'(1'b1);
               end
            end else begin
               cnt_nx_s = cnt_r - CNT_W'(1'b1);
            end
         end

         ST_LOW: begin
            if (ABORT) begin
               state_nx_s = ST_IDLE;
            end else if (cnt_r == {CNT_W{1'b0}}) begin
               state_nx_s = ST_HIGH;
               cnt_nx_s   = wid_wrk_r - CNT_W'(1'b1);
            end else begin
               cnt_nx_s = cnt_r - CNT_W'(1'b1);
            end
         end

         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase

      // A write that arrives while a train runs is dropped and flagged.
      if (CFG_WE && !idle_s) begin
         err_nx_s = 1'b1;
      end else begin
         err_nx_s = err_nx_s;
      end
   end

   // Sequencer registers and registered outputs derived from the next state.
   always_ff @(posedge CLK200M) begin
      if (RESET) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         rep_r     <= {REP_W{1'b0}};
         wid_wrk_r <= {CNT_W{1'b0}};
         gap_wrk_r <= {CNT_W{1'b0}};
         trg_pls_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         cfg_err_r <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         cnt_r     <= cnt_nx_s;
         rep_r     <= rep_nx_s;
         wid_wrk_r <= wid_wrk_nx_s;
         gap_wrk_r <= gap_wrk_nx_s;
         trg_pls_r <= (state_nx_s == ST_HIGH);
         busy_r    <= (state_nx_s != ST_IDLE);
         done_r    <= done_nx_s;
         cfg_err_r <= err_nx_s;
      end
   end

   // Configuration write port; writes only land while the sequencer is idle.
   // A start in the same cycle snapshots the old values because the
   // snapshot reads these registers before this edge updates them.
   always_ff @(posedge CLK200M) begin
      if (RESET) begin
         dly_cfg_r <= {CNT_W{1'b0}};
         wid_cfg_r <= CNT_W'(1'b1);
         per_cfg_r <= CNT_W'(2'd2);
         rep_cfg_r <= REP_W'(1'b1);
      end else if (CFG_WE && idle_s) begin
         case (CFG_ADDR)
            2'd0:    dly_cfg_r <= CFG_WDATA;
            2'd1:    wid_cfg_r <= CFG_WDATA;
            2'd2:    per_cfg_r <= CFG_WDATA;
            2'd3:    rep_cfg_r <= CFG_WDATA[REP_W-1:0];
            default: dly_cfg_r <= dly_cfg_r;
         endcase
      end else begin
         dly_cfg_r <= dly_cfg_r;
      end
   end

   assign TRG_PLS = trg_pls_r;
   assign BUSY    = busy_r;
   assign DONE    = done_r;
   assign CFG_ERR = cfg_err_r;

endmodule
